fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives pc to instruction memory, registers the returned instruction for decode.
// Latency: one cycle from pc to id_*; one instruction per cycle when decode keeps id_ready high.
// Backpressure: id_valid && !id_ready freezes pc and id_*; a redirect always wins and flushes id_valid.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_compressed handshake counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000006C
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_compressed,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_next,
    output logic        id_compressed,
    output logic        fetch_fault,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_compressed
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Bit 0 of the fetch address is structurally zero, so only [31:1] is stored.
    logic [31:1] pc_q;
    logic [31:1] pc_nxt;

    // Sequential successor of the current pc; also the link value handed to decode.
    logic [31:0] seq_pc;

    logic        capture;
    logic        flush;
    logic        fault_set;

    assign pc = {pc_q, 1'b0};

    // Next sequential address, modulo 2^32 by construction of the 32-bit add.
    always_comb begin
        seq_pc = pc + (imem_compressed ? 32'd2 : 32'd4);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and fetch control: redirect beats capture beats stall.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        capture   = 1'b0;
        flush     = 1'b0;
        fault_set = 1'b0;
        case (state)
            ST_BOOT: begin
                // Boot cycle never captures; a redirect seen here is still honoured.
                state_nxt = ST_RUN;
                if (redirect_valid) begin
                    if (redirect_pc[0]) begin
                        state_nxt = ST_FAULT;
                        fault_set = 1'b1;
                    end else begin
                        pc_nxt = redirect_pc[31:1];
                        flush  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    if (redirect_pc[0]) begin
                        // Odd target: freeze pc and park in FAULT until reset.
                        state_nxt = ST_FAULT;
                        fault_set = 1'b1;
                    end else begin
                        pc_nxt = redirect_pc[31:1];
                        flush  = 1'b1;
                    end
                end else if (!id_valid || id_ready) begin
                    capture = 1'b1;
                    pc_nxt  = seq_pc[31:1];
                end
            end
            ST_FAULT: begin
                // Terminal: ignore redirects and never capture.
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Fetch address register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC[31:1];
        end else begin
            pc_q <= pc_nxt;
        end
    end

    // Decode-facing pipeline register; id_* payload only changes on a capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid      <= 1'b0;
            id_instr      <= 32'd0;
            id_pc         <= 32'd0;
            id_pc_next    <= 32'd0;
            id_compressed <= 1'b0;
        end else if (capture) begin
            id_valid      <= 1'b1;
            id_instr      <= imem_instr;
            id_pc         <= pc;
            id_pc_next    <= seq_pc;
            id_compressed <= imem_compressed;
        end else if (flush || fault_set || id_ready) begin
            id_valid <= 1'b0;
        end
    end

    // Sticky misaligned-redirect flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (fault_set) begin
            fetch_fault <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_compressed_q;

    // Count every decode handshake, including one that coincides with a redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q    <= 32'd0;
            perf_compressed_q <= 32'd0;
        end else if (id_valid && id_ready) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
            if (id_compressed) begin
                perf_compressed_q <= perf_compressed_q + 32'd1;
            end
        end
    end

    assign perf_fetched    = perf_fetched_q;
    assign perf_compressed = perf_compressed_q;
`else
    assign perf_fetched    = 32'd0;
    assign perf_compressed = 32'd0;
`endif

endmodule
